// File: rtl/network_bf_in.sv
// rtl/network_bf_in.sv - read-side routing of bank words to butterfly operands
//
// Purpose: delays the bank-select set by the bank read latency, routes the
// four returning bank words (q0..q3) to the two butterfly units' upper/lower
// inputs (optionally swapped for INTT mode), registers them, flags bank
// conflicts and counts groups to mark the end of a stage.
//
// Ports:
//   clk                   system clock, rising edge
//   rst                   asynchronous active-low reset
//   clr                   synchronous clear of conflict flag and group counter
//   valid_in              select set issued this cycle (with bank read request)
//   sel                   mode, 0 = NTT, 1 = INTT (swap upper/lower)
//   sel_b_0..sel_b_3      bank codes for bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower
//   q0..q3                bank read data, RD_LAT cycles after the request
//   bf_0_upper..bf_1_lower registered butterfly operands
//   out_valid             operands valid
//   conflict              sticky bank-conflict flag
//   done                  one-cycle pulse on the last group of a stage

module network_bf_in #(
    parameter int data_width = 12,
    parameter int RD_LAT     = 1,
    parameter int N_GROUPS   = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  valid_in,
    input  logic                  sel,
    input  logic [1:0]            sel_b_0,
    input  logic [1:0]            sel_b_1,
    input  logic [1:0]            sel_b_2,
    input  logic [1:0]            sel_b_3,
    input  logic [data_width-1:0] q0,
    input  logic [data_width-1:0] q1,
    input  logic [data_width-1:0] q2,
    input  logic [data_width-1:0] q3,
    output logic [data_width-1:0] bf_0_upper,
    output logic [data_width-1:0] bf_0_lower,
    output logic [data_width-1:0] bf_1_upper,
    output logic [data_width-1:0] bf_1_lower,
    output logic                  out_valid,
    output logic                  conflict,
    output logic                  done
);

    localparam int CW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam logic [CW-1:0] LAST_GROUP = CW'(N_GROUPS - 1);

    // Select set layout: {valid, sel, sel_b_0, sel_b_1, sel_b_2, sel_b_3}
    localparam int PW = 10;

    logic [PW-1:0]         r_pipe [RD_LAT];
    logic [PW-1:0]         w_issue;
    logic [PW-1:0]         w_dly;
    logic                  w_d_valid;
    logic                  w_d_sel;
    logic [1:0]            w_d_sb0;
    logic [1:0]            w_d_sb1;
    logic [1:0]            w_d_sb2;
    logic [1:0]            w_d_sb3;
    logic [data_width-1:0] w_q [4];
    logic [data_width-1:0] w_r0u;
    logic [data_width-1:0] w_r0l;
    logic [data_width-1:0] w_r1u;
    logic [data_width-1:0] w_r1l;
    logic                  w_conf_hit;
    logic [CW-1:0]         r_grp_cnt;

    assign w_issue = {valid_in, sel, sel_b_0, sel_b_1, sel_b_2, sel_b_3};

    // Shift chain: the set issued with the read request reaches the last
    // stage in the same cycle that its bank data is returned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_dly     = r_pipe[RD_LAT-1];
    assign w_d_valid = w_dly[9];
    assign w_d_sel   = w_dly[8];
    assign w_d_sb0   = w_dly[7:6];
    assign w_d_sb1   = w_dly[5:4];
    assign w_d_sb2   = w_dly[3:2];
    assign w_d_sb3   = w_dly[1:0];

    assign w_q[0] = q0;
    assign w_q[1] = q1;
    assign w_q[2] = q2;
    assign w_q[3] = q3;

    // INTT mode exchanges upper and lower within each butterfly.
    always_comb begin
        w_r0u = w_q[w_d_sb0];
        w_r0l = w_q[w_d_sb1];
        w_r1u = w_q[w_d_sb2];
        w_r1l = w_q[w_d_sb3];
        if (w_d_sel) begin
            w_r0u = w_q[w_d_sb1];
            w_r0l = w_q[w_d_sb0];
            w_r1u = w_q[w_d_sb3];
            w_r1l = w_q[w_d_sb2];
        end
    end

    // Operands hold their last values through gaps in the group stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bf_0_upper <= '0;
            bf_0_lower <= '0;
            bf_1_upper <= '0;
            bf_1_lower <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= w_d_valid;
            if (w_d_valid) begin
                bf_0_upper <= w_r0u;
                bf_0_lower <= w_r0l;
                bf_1_upper <= w_r1u;
                bf_1_lower <= w_r1l;
            end
        end
    end

    // Conflict is judged on the set as issued, so it shows one cycle later.
    assign w_conf_hit = valid_in &&
                        ((sel_b_0 == sel_b_1) || (sel_b_0 == sel_b_2) ||
                         (sel_b_0 == sel_b_3) || (sel_b_1 == sel_b_2) ||
                         (sel_b_1 == sel_b_3) || (sel_b_2 == sel_b_3));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict <= 1'b0;
        end else if (w_conf_hit) begin
            conflict <= 1'b1;
        end else if (clr) begin
            conflict <= 1'b0;
        end
    end

    // Counter holds the number of groups already emitted in this stage, so
    // it reads LAST_GROUP while the final group is on the outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grp_cnt <= '0;
        end else if (clr) begin
            r_grp_cnt <= '0;
        end else if (out_valid) begin
            if (r_grp_cnt == LAST_GROUP) begin
                r_grp_cnt <= '0;
            end else begin
                r_grp_cnt <= r_grp_cnt + CW'(1);
            end
        end
    end

    assign done = out_valid && (r_grp_cnt == LAST_GROUP);

endmodule

// File: tb/tb_network_bf_in.sv
// tb/tb_network_bf_in.sv - directed self-checking bench for network_bf_in

module tb_network_bf_in;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        valid_in;
    logic        sel;
    logic [1:0]  sel_b_0, sel_b_1, sel_b_2, sel_b_3;
    logic [11:0] q0, q1, q2, q3;

    logic [11:0] bf0u [3];
    logic [11:0] bf0l [3];
    logic [11:0] bf1u [3];
    logic [11:0] bf1l [3];
    logic        ov   [3];
    logic        conf [3];
    logic        dn   [3];

    int n_checks;
    int n_errors;

    network_bf_in #(.data_width(12), .RD_LAT(1), .N_GROUPS(128)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .valid_in(valid_in), .sel(sel),
        .sel_b_0(sel_b_0), .sel_b_1(sel_b_1), .sel_b_2(sel_b_2), .sel_b_3(sel_b_3),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .bf_0_upper(bf0u[0]), .bf_0_lower(bf0l[0]), .bf_1_upper(bf1u[0]), .bf_1_lower(bf1l[0]),
        .out_valid(ov[0]), .conflict(conf[0]), .done(dn[0])
    );

    network_bf_in #(.data_width(12), .RD_LAT(2), .N_GROUPS(128)) u2 (
        .clk(clk), .rst(rst), .clr(clr), .valid_in(valid_in), .sel(sel),
        .sel_b_0(sel_b_0), .sel_b_1(sel_b_1), .sel_b_2(sel_b_2), .sel_b_3(sel_b_3),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .bf_0_upper(bf0u[1]), .bf_0_lower(bf0l[1]), .bf_1_upper(bf1u[1]), .bf_1_lower(bf1l[1]),
        .out_valid(ov[1]), .conflict(conf[1]), .done(dn[1])
    );

    network_bf_in #(.data_width(12), .RD_LAT(3), .N_GROUPS(128)) u3 (
        .clk(clk), .rst(rst), .clr(clr), .valid_in(valid_in), .sel(sel),
        .sel_b_0(sel_b_0), .sel_b_1(sel_b_1), .sel_b_2(sel_b_2), .sel_b_3(sel_b_3),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .bf_0_upper(bf0u[2]), .bf_0_lower(bf0l[2]), .bf_1_upper(bf1u[2]), .bf_1_lower(bf1l[2]),
        .out_valid(ov[2]), .conflict(conf[2]), .done(dn[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic s, input logic [1:0] a,
                         input logic [1:0] b, input logic [1:0] c, input logic [1:0] d);
        valid_in = v;
        sel      = s;
        sel_b_0  = a;
        sel_b_1  = b;
        sel_b_2  = c;
        sel_b_3  = d;
    endtask

    logic       iv   [10];
    logic       isel [10];
    logic [11:0] m0u, m0l, m1u, m1l;
    int          g;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        clr = 1'b0;
        issue(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        q0 = 12'h001; q1 = 12'h002; q2 = 12'h003; q3 = 12'h004;
        step();
        step();
        check("rst_ov", ov[0], 0);
        check("rst_bf", {bf0u[0], bf0l[0], bf1u[0], bf1l[0]}, 0);
        check("rst_conf", conf[0], 0);
        check("rst_done", dn[0], 0);
        rst = 1'b1;

        // NTT routing, RD_LAT=1
        issue(1'b1, 1'b0, 2'd0, 2'd1, 2'd2, 2'd3);
        step();
        issue(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        check("ntt_ov_t1", ov[0], 0);
        step();
        check("ntt_ov", ov[0], 1);
        check("ntt_b0u", bf0u[0], 12'h001);
        check("ntt_b0l", bf0l[0], 12'h002);
        check("ntt_b1u", bf1u[0], 12'h003);
        check("ntt_b1l", bf1l[0], 12'h004);
        check("ntt_conf", conf[0], 0);

        // INTT swap
        issue(1'b1, 1'b1, 2'd0, 2'd1, 2'd2, 2'd3);
        step();
        issue(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        step();
        check("intt_ov", ov[0], 1);
        check("intt_b0u", bf0u[0], 12'h002);
        check("intt_b0l", bf0l[0], 12'h001);
        check("intt_b1u", bf1u[0], 12'h004);
        check("intt_b1l", bf1l[0], 12'h003);
        step();
        check("intt_ov_drop", ov[0], 0);

        // Full stage on RD_LAT=3
        for (int i = 0; i < 5; i++) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int c = 0; c < 136; c++) begin
            if (c < 128)
                issue(1'b1, 1'b0, 2'(c % 4), 2'((c + 1) % 4), 2'((c + 2) % 4), 2'((c + 3) % 4));
            else
                issue(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
            step();
            g = c - 3;
            check($sformatf("stage_ov_%0d", c), ov[2], (g >= 0 && g < 128) ? 1 : 0);
            check($sformatf("stage_done_%0d", c), dn[2], (g == 127) ? 1 : 0);
            if (g >= 0 && g < 128) begin
                check($sformatf("stage_b0u_%0d", c), bf0u[2], 32'((g % 4) + 1));
                check($sformatf("stage_b1l_%0d", c), bf1l[2], 32'(((g + 3) % 4) + 1));
            end
        end
        check("stage_cnt_wrap", 32'(u3.r_grp_cnt), 0);

        // Conflict on RD_LAT=1
        issue(1'b1, 1'b0, 2'd2, 2'd2, 2'd0, 2'd1);
        step();
        issue(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        check("conf_set", conf[0], 1);
        step();
        check("conf_hold", conf[0], 1);
        check("conf_ov", ov[0], 1);
        check("conf_b0u", bf0u[0], 12'h003);
        check("conf_b0l", bf0l[0], 12'h003);
        check("conf_b1u", bf1u[0], 12'h001);
        check("conf_b1l", bf1l[0], 12'h002);
        clr = 1'b1;
        step();
        check("conf_clr", conf[0], 0);
        issue(1'b1, 1'b0, 2'd1, 2'd3, 2'd1, 2'd0);
        step();
        clr = 1'b0;
        issue(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        check("conf_set_wins", conf[0], 1);

        // Mid-flight reset on RD_LAT=2
        for (int i = 0; i < 4; i++) step();
        issue(1'b1, 1'b0, 2'd0, 2'd1, 2'd2, 2'd3);
        step();
        issue(1'b1, 1'b1, 2'd0, 2'd1, 2'd2, 2'd3);
        step();
        issue(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        rst = 1'b0;
        #1;
        check("mrst_ov", ov[1], 0);
        check("mrst_bf", {bf0u[1], bf0l[1], bf1u[1], bf1l[1]}, 0);
        check("mrst_conf", conf[1], 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("mrst_flush_ov_%0d", i), ov[1], 0);
            check($sformatf("mrst_flush_done_%0d", i), dn[1], 0);
        end
        issue(1'b1, 1'b0, 2'd3, 2'd2, 2'd1, 2'd0);
        step();
        issue(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        check("mrst_new_t1", ov[1], 0);
        step();
        check("mrst_new_t2", ov[1], 0);
        step();
        check("mrst_new_t3", ov[1], 1);
        check("mrst_new_b0u", bf0u[1], 12'h004);
        check("mrst_new_b1l", bf1l[1], 12'h001);

        // Alternating groups with per-group mode on RD_LAT=1
        rst = 1'b0;
        step();
        rst = 1'b1;
        m0u = '0; m0l = '0; m1u = '0; m1l = '0;
        for (int c = 0; c < 10; c++) begin
            iv[c]   = (c % 2 == 0) && (c < 6);
            isel[c] = ((c / 2) % 2) == 1;
            issue(iv[c], isel[c], 2'd0, 2'd1, 2'd2, 2'd3);
            step();
            if (c >= 1 && iv[c-1]) begin
                if (isel[c-1]) begin
                    m0u = 12'h002; m0l = 12'h001; m1u = 12'h004; m1l = 12'h003;
                end else begin
                    m0u = 12'h001; m0l = 12'h002; m1u = 12'h003; m1l = 12'h004;
                end
            end
            check($sformatf("alt_ov_%0d", c), ov[0], (c >= 1 && iv[c-1]) ? 1 : 0);
            check($sformatf("alt_bf_%0d", c), {bf0u[0], bf0l[0], bf1u[0], bf1l[0]},
                  {m0u, m0l, m1u, m1l});
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
